// File: rtl/svm_lane_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// svm_sched_pkg
// Shared types and helpers for the SVM lane dispatcher.
//   lane_state_t   : per-lane lifecycle (IDLE -> ISSUE -> BUSY -> IDLE)
//   COUNTER_W      : width of every performance counter
//   MAX_DEPS_LIMIT : widest dependency vector the conflict helper handles
//   conflict_vec() : returns {raw, waw, war} overlap flags of a candidate
//                    transaction against the currently held locks
// ---------------------------------------------------------------------------
package svm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } lane_state_t;

    localparam int COUNTER_W      = 32;
    localparam int MAX_DEPS_LIMIT = 256;

    // Callers zero-extend narrower dependency vectors to MAX_DEPS_LIMIT.
    // Read-read overlap is deliberately not reported.
    function automatic logic [2:0] conflict_vec(
        input logic [MAX_DEPS_LIMIT-1:0] rd,
        input logic [MAX_DEPS_LIMIT-1:0] wr,
        input logic [MAX_DEPS_LIMIT-1:0] act_rd,
        input logic [MAX_DEPS_LIMIT-1:0] act_wr
    );
        logic raw;
        logic waw;
        logic war;
        raw = |(rd & act_wr);
        waw = |(wr & act_wr);
        war = |(wr & act_rd);
        return {raw, waw, war};
    endfunction

endpackage

// File: rtl/svm_lane_dispatcher_if.sv
// ---------------------------------------------------------------------------
// svm_lane_dispatcher_if
// Bundles the scheduler input stream and the per-lane issue/complete bus.
//   s_axis_*                : transaction stream from the scheduler
//   lane_valid / lane_ready : per-lane issue handshake
//   lane_*_dependencies     : per-lane transaction data, lane i at [W*i +: W]
//   lane_done               : one-cycle completion pulse per lane
// Modports:
//   slave  : the dispatcher
//   master : the environment (scheduler + lanes)
// ---------------------------------------------------------------------------
interface svm_lane_dispatcher_if #(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_LANES        = 4
);

    logic                                  s_axis_tvalid;
    logic                                  s_axis_tready;
    logic [63:0]                           s_axis_tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0]           s_axis_tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0]           s_axis_tdata_write_dependencies;

    logic [NUM_LANES-1:0]                  lane_valid;
    logic [NUM_LANES-1:0]                  lane_ready;
    logic [64*NUM_LANES-1:0]               lane_owner_programID;
    logic [MAX_DEPENDENCIES*NUM_LANES-1:0] lane_read_dependencies;
    logic [MAX_DEPENDENCIES*NUM_LANES-1:0] lane_write_dependencies;
    logic [NUM_LANES-1:0]                  lane_done;

    modport slave (
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tdata_owner_programID,
        input  s_axis_tdata_read_dependencies,
        input  s_axis_tdata_write_dependencies,
        output lane_valid,
        input  lane_ready,
        output lane_owner_programID,
        output lane_read_dependencies,
        output lane_write_dependencies,
        input  lane_done
    );

    modport master (
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tdata_owner_programID,
        output s_axis_tdata_read_dependencies,
        output s_axis_tdata_write_dependencies,
        input  lane_valid,
        output lane_ready,
        input  lane_owner_programID,
        input  lane_read_dependencies,
        input  lane_write_dependencies,
        output lane_done
    );

endinterface

// File: rtl/svm_lane_dispatcher_rr_idle_picker.sv
// ---------------------------------------------------------------------------
// rr_idle_picker
// Combinational round-robin priority encoder: grants the first set bit of
// idle at an index >= rr_ptr, wrapping modulo NUM_LANES.
//   idle        : in  NUM_LANES  lanes currently IDLE
//   rr_ptr      : in  PTR_W      search start index (0..NUM_LANES-1)
//   grant       : out NUM_LANES  one-hot chosen lane
//   grant_valid : out 1          some lane was chosen
// ---------------------------------------------------------------------------
module rr_idle_picker #(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_LANES-1:0] idle,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic                 grant_valid
);

    int             pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        pos         = 0;
        idx         = '0;
        for (int off = 0; off < NUM_LANES; off++) begin
            pos = (int'(rr_ptr) + off) % NUM_LANES;
            idx = PTR_W'(pos);
            if (!grant_valid && idle[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svm_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// svm_lane_dispatcher
// Accepts transactions from the SVM scheduler into a one-entry head register
// and issues them to NUM_LANES execution lanes, but only once the head's
// read/write sets do not overlap (RAW, WAW, WAR) the locks held by lanes in
// ISSUE or BUSY. Lanes are picked round-robin; a lane's locks are released
// on its lane_done pulse while BUSY.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   bus (slave modport)    : scheduler stream + per-lane issue bus
//   all_idle               : head empty and every lane IDLE
//   dispatched_count       : transactions issued to lanes
//   completed_count        : accepted lane_done pulses
//   conflict_stall_cycles  : cycles the head was blocked by a lock overlap
//   lane_stall_cycles      : cycles the head was conflict-free but no lane idle
// ---------------------------------------------------------------------------
module svm_lane_dispatcher
    import svm_sched_pkg::*;
#(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_LANES        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svm_lane_dispatcher_if.slave bus,
    output logic                 all_idle,
    output logic [COUNTER_W-1:0] dispatched_count,
    output logic [COUNTER_W-1:0] completed_count,
    output logic [COUNTER_W-1:0] conflict_stall_cycles,
    output logic [COUNTER_W-1:0] lane_stall_cycles
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // Head register
    logic                        head_valid;
    logic                        head_valid_nxt;
    logic [63:0]                 head_owner;
    logic [MAX_DEPENDENCIES-1:0] head_rd;
    logic [MAX_DEPENDENCIES-1:0] head_wr;
    logic                        tready_q;
    logic                        accept;

    // Lane state and data
    lane_state_t                 lane_state     [NUM_LANES];
    lane_state_t                 lane_state_nxt [NUM_LANES];
    logic [63:0]                 lane_owner     [NUM_LANES];
    logic [MAX_DEPENDENCIES-1:0] lane_rd        [NUM_LANES];
    logic [MAX_DEPENDENCIES-1:0] lane_wr        [NUM_LANES];

    // Arbitration and locking
    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            rr_ptr_nxt;
    logic [PTR_W-1:0]            chosen;
    logic [NUM_LANES-1:0]        idle_mask;
    logic [NUM_LANES-1:0]        grant;
    logic                        grant_valid;
    logic [MAX_DEPENDENCIES-1:0] act_rd;
    logic [MAX_DEPENDENCIES-1:0] act_wr;
    logic [2:0]                  conflict_bits;
    logic                        conflict;
    logic                        dispatch;
    logic [COUNTER_W-1:0]        done_inc;

    // Flattened lane outputs
    logic [NUM_LANES-1:0]                  lane_valid_w;
    logic [64*NUM_LANES-1:0]               owner_flat;
    logic [MAX_DEPENDENCIES*NUM_LANES-1:0] rd_flat;
    logic [MAX_DEPENDENCIES*NUM_LANES-1:0] wr_flat;

    assign accept = bus.s_axis_tvalid && tready_q;

    // Locks come only from registered lane state, so a lane released by
    // lane_done this edge stops blocking from the next cycle on.
    always_comb begin
        idle_mask = '0;
        act_rd    = '0;
        act_wr    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idle_mask[i] = (lane_state[i] == IDLE);
            if (lane_state[i] != IDLE) begin
                act_rd = act_rd | lane_rd[i];
                act_wr = act_wr | lane_wr[i];
            end
        end
    end

    assign conflict_bits = conflict_vec(MAX_DEPS_LIMIT'(head_rd), MAX_DEPS_LIMIT'(head_wr),
                                        MAX_DEPS_LIMIT'(act_rd),  MAX_DEPS_LIMIT'(act_wr));
    assign conflict      = |conflict_bits;

    rr_idle_picker #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_picker (
        .idle        (idle_mask),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign dispatch = head_valid && !conflict && grant_valid;

    always_comb begin
        chosen = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                chosen = PTR_W'(i);
            end
        end
        rr_ptr_nxt = rr_ptr;
        if (dispatch) begin
            rr_ptr_nxt = (chosen == PTR_W'(NUM_LANES-1)) ? '0 : chosen + 1'b1;
        end
    end

    // A head load and a dispatch never coincide: tready is only high while
    // the head is empty.
    always_comb begin
        head_valid_nxt = head_valid;
        if (accept) begin
            head_valid_nxt = 1'b1;
        end else if (dispatch) begin
            head_valid_nxt = 1'b0;
        end
    end

    // Lane next-state; lane_done outside BUSY is ignored and not counted.
    always_comb begin
        done_inc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_state_nxt[i] = lane_state[i];
            case (lane_state[i])
                IDLE: begin
                    if (dispatch && grant[i]) begin
                        lane_state_nxt[i] = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.lane_ready[i]) begin
                        lane_state_nxt[i] = BUSY;
                    end
                end
                BUSY: begin
                    if (bus.lane_done[i]) begin
                        lane_state_nxt[i] = IDLE;
                        done_inc          = done_inc + COUNTER_W'(1);
                    end
                end
                default: lane_state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_state[i] <= lane_state_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_owner[i] <= '0;
                lane_rd[i]    <= '0;
                lane_wr[i]    <= '0;
            end
        end else if (dispatch) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (grant[i]) begin
                    lane_owner[i] <= head_owner;
                    lane_rd[i]    <= head_rd;
                    lane_wr[i]    <= head_wr;
                end
            end
        end
    end

    // tready is registered as the inverse of the next head occupancy, so it
    // is low in reset and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= 1'b0;
            tready_q   <= 1'b0;
            head_owner <= '0;
            head_rd    <= '0;
            head_wr    <= '0;
            rr_ptr     <= '0;
        end else begin
            head_valid <= head_valid_nxt;
            tready_q   <= !head_valid_nxt;
            rr_ptr     <= rr_ptr_nxt;
            if (accept) begin
                head_owner <= bus.s_axis_tdata_owner_programID;
                head_rd    <= bus.s_axis_tdata_read_dependencies;
                head_wr    <= bus.s_axis_tdata_write_dependencies;
            end
        end
    end

    // Exactly one stall counter advances per cycle the head waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatched_count      <= '0;
            completed_count       <= '0;
            conflict_stall_cycles <= '0;
            lane_stall_cycles     <= '0;
        end else begin
            completed_count <= completed_count + done_inc;
            if (dispatch) begin
                dispatched_count <= dispatched_count + COUNTER_W'(1);
            end else if (head_valid) begin
                if (conflict) begin
                    conflict_stall_cycles <= conflict_stall_cycles + COUNTER_W'(1);
                end else begin
                    lane_stall_cycles <= lane_stall_cycles + COUNTER_W'(1);
                end
            end
        end
    end

    always_comb begin
        lane_valid_w = '0;
        owner_flat   = '0;
        rd_flat      = '0;
        wr_flat      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_valid_w[i]                                  = (lane_state[i] == ISSUE);
            owner_flat[64*i +: 64]                           = lane_owner[i];
            rd_flat[MAX_DEPENDENCIES*i +: MAX_DEPENDENCIES]  = lane_rd[i];
            wr_flat[MAX_DEPENDENCIES*i +: MAX_DEPENDENCIES]  = lane_wr[i];
        end
    end

    assign bus.s_axis_tready           = tready_q;
    assign bus.lane_valid              = lane_valid_w;
    assign bus.lane_owner_programID    = owner_flat;
    assign bus.lane_read_dependencies  = rd_flat;
    assign bus.lane_write_dependencies = wr_flat;
    assign all_idle                    = !head_valid && (&idle_mask);

endmodule

// File: doc/svm_lane_dispatcher.md
# svm_lane_dispatcher

Sits downstream of the SVM scheduler's output stream and issues conflict-free transactions to NUM_LANES parallel execution lanes. Holds the read/write dependency masks of every in-flight transaction as locks and admits a new transaction only when it has no RAW, WAW or WAR overlap with those locks. Picks a free lane round-robin and releases the lane's locks on the lane's completion pulse. Exposes stall and throughput counters for performance monitoring.

## Interface
- MAX_DEPENDENCIES, 256: dependency vector width.
- NUM_LANES, 4: execution lanes, 2..8.
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  transaction valid from scheduler.
- s_axis_tready  out  1  dispatcher can accept.
- s_axis_tdata_owner_programID  in  64  owner program ID.
- s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  read set.
- s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  write set.
- lane_valid  out  NUM_LANES  per-lane issue valid.
- lane_ready  in  NUM_LANES  per-lane issue accept.
- lane_owner_programID  out  64*NUM_LANES  per-lane owner; lane i at [64*i +: 64].
- lane_read_dependencies  out  MAX_DEPENDENCIES*NUM_LANES  per-lane read set.
- lane_write_dependencies  out  MAX_DEPENDENCIES*NUM_LANES  per-lane write set.
- lane_done  in  NUM_LANES  one-cycle completion pulse per lane.
- all_idle  out  1  head empty and every lane IDLE.
- dispatched_count  out  32  transactions issued to lanes.
- completed_count  out  32  accepted lane_done pulses.
- conflict_stall_cycles  out  32  cycles head blocked by lock overlap.
- lane_stall_cycles  out  32  cycles head conflict-free but no IDLE lane.

## Operation
- Head register, one entry. s_axis_tready = !head_valid, driven from a register. Handshake when tvalid && tready loads the head.
- Per-lane FSM:
  - IDLE -> ISSUE on dispatch.
  - ISSUE (lane_valid=1) -> BUSY when lane_ready=1.
  - BUSY -> IDLE when lane_done=1.
  - lane_done in IDLE or ISSUE is ignored and not counted.
- Active locks: act_rd = OR of read masks, act_wr = OR of write masks, over lanes in ISSUE or BUSY. Both are built from registered state only.
- Conflict = |(head_rd & act_wr) | |(head_wr & act_wr) | |(head_wr & act_rd). Read-read overlap is allowed.
- Dispatch condition: head_valid && !conflict && any IDLE lane. The target is the first IDLE lane at index >= rr_ptr, wrapping modulo NUM_LANES.
- On dispatch: copy the head into the lane's data registers, set the lane to ISSUE, clear head_valid, set rr_ptr = chosen+1 (wraps to 0 after NUM_LANES-1), and increment dispatched_count.
- Lane data registers hold their value through ISSUE and BUSY; their contents in IDLE are don't-care.
- Stall counters: each cycle head_valid is set without a dispatch, increment exactly one counter. conflict_stall_cycles if conflict; otherwise lane_stall_cycles.
- All counters are 32-bit and wrap silently from 0xFFFFFFFF to 0.
- A transaction with all-zero read and write sets never conflicts.

## Timing
- Reset values: s_axis_tready=0, lane_valid=0, all lanes IDLE, rr_ptr=0, head_valid=0, all counters=0, all_idle=1, lane data=0.
- s_axis_tready rises on the first clock edge after rst_n deasserts.
- Latency: an input handshake at edge N gives lane_valid=1 after edge N+1, provided the transaction is conflict-free and a lane is IDLE.
- Throughput: at most one transaction per 2 cycles, because tready is low while the head is occupied.
- lane_done at edge N: the lane is IDLE and its locks are released after edge N; a blocked head can dispatch at edge N+1. The released lane is not reusable in the same cycle as its lane_done.
- lane_valid, once set, stays high until lane_ready; data is stable throughout.
- Reset asserted mid-operation aborts everything immediately: all locks are dropped and the in-flight head is discarded.

## Structure
- Shared package svm_sched_pkg holds:
  - lane_state_t enum {IDLE, ISSUE, BUSY};
  - localparam COUNTER_W=32;
  - function conflict_vec(rd, wr, act_rd, act_wr), returning {raw, waw, war}.
- Sub-module rr_idle_picker: NUM_LANES-wide round-robin priority encoder. Inputs: idle mask and rr_ptr. Outputs: grant one-hot and grant_valid. Purely combinational.

## Test plan
- Reset, then T1 (rd=0x1, wr=0x2): lane_valid=4'b0001 two cycles after the handshake, with lane 0 owner=1; dispatched_count=1.
- T1 BUSY on lane 0, then T2 rd=0x2 (RAW): T2 is held and conflict_stall_cycles increments each cycle. Pulse lane_done[0]: T2 issues on lane 1 one cycle later; completed_count=1.
- With T1 active, T3 wr=0x2 (WAW) stalls and T4 wr=0x1 (WAR) stalls. T5 rd=0x1 (read-read with T1) dispatches with no stall.
- Four disjoint transactions (wr=bit0..bit3) with lanes never done: lanes 0,1,2,3 fill in order. A fifth disjoint transaction raises lane_stall_cycles; lane_done[2] sends it to lane 2.
- Hold lane_ready[0]=0 for 10 cycles: lane_valid[0] and the lane data are stable. Lane 0 then moves to BUSY, and spurious lane_done[0] during ISSUE is ignored.
- Reset asserted while 3 lanes are BUSY and the head is full: all outputs return to reset values immediately; all_idle=1.
